// File: rtl/mem_if_pkg.sv
// Shared types and constants for the memory responder.
// Widths, FSM states and latency bounds.
package mem_if_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Word storage with byte-strobed synchronous write.
// Read port is combinational; the caller captures it.
module mem_responder_array
  import mem_if_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 256,
  localparam int AW    = $clog2(DEPTH),
  localparam int SW    = strb_w(DATA_W)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [SW-1:0]     wstrb,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // byte-lane write, no reset on storage
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < SW; i++) begin
        if (wstrb[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory target with fixed latency.
// Request accepted in IDLE, answered RD_LAT cycles later.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [DATA_W-1:0]           req_wdata,
  input  logic [strb_w(DATA_W)-1:0]   req_wstrb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic                        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("mem_responder: RD_LAT out of range");
  end
  if (DATA_W % 8 != 0) begin : g_bad_dw
    $error("mem_responder: DATA_W not a multiple of 8");
  end

  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic accept;
  logic in_range;
  logic retire;
  logic [DATA_W-1:0] arr_rdata;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign accept    = req_valid & req_ready;
  assign retire    = rsp_valid & rsp_ready;
  assign in_range  = {1'b0, req_addr} < LIMIT;

  mem_responder_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (accept & req_write & in_range),
    .addr  (req_addr[AW-1:0]),
    .wdata (req_wdata),
    .wstrb (req_wstrb),
    .rdata (arr_rdata)
  );

  // next state and latency counter
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          cnt_n   = LAT_M1;
          state_n = (RD_LAT > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_n = cnt - 3'd1;
        if (cnt == 3'd1) state_n = RESP;
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // response register, loaded at acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_err   <= ~in_range;
      rsp_rdata <= (!req_write && in_range) ? arr_rdata : '0;
    end else if (retire) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule
